// File: rtl/count_uart_pkg.sv
// count_uart_pkg: FSM states and ASCII constants shared by the count UART transmitter
package count_uart_pkg;
    typedef enum logic [1:0] {IDLE, CONV, SEND, WAIT} state_t;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int FRAME_BYTES = 5;
endpackage

// File: rtl/count_uart_tx_if.sv
// count_uart_tx_if: count-in / UART-out signal bundle
// data_in, load_in: count value and gate pulse toward the block
// tx_out, busy_out, overrun_out: serial line, frame-in-progress, sticky dropped-load flag
interface count_uart_tx_if;
    logic [7:0] data_in;
    logic       load_in;
    logic       tx_out;
    logic       busy_out;
    logic       overrun_out;
    modport master (output data_in, load_in, input tx_out, busy_out, overrun_out);
    modport slave (input data_in, load_in, output tx_out, busy_out, overrun_out);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte
// clk_in, rst_n_in: clock, async active-low reset; start, data: byte request
// tx: serial line (idle high); busy: frame in progress; done: last cycle of stop bit
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
    logic [BW-1:0] baud;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          bit_end;
    assign bit_end = busy && baud == LAST;
    assign done = bit_end && bit_cnt == 4'd9;
    // shreg holds the not-yet-sent bits (data then stop), shifted out LSB first
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx <= 1'b1;
            busy <= 1'b0;
            baud <= '0;
            bit_cnt <= '0;
            shreg <= '0;
        end else if (!busy) begin
            if (start) begin
                busy <= 1'b1;
                tx <= 1'b0;
                shreg <= {1'b1, data};
                baud <= '0;
                bit_cnt <= '0;
            end
        end else if (bit_end) begin
            baud <= '0;
            if (done) begin
                busy <= 1'b0;
                tx <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                tx <= shreg[0];
                shreg <= {1'b1, shreg[8:1]};
            end
        end else begin
            baud <= baud + 1'b1;
        end
    end
endmodule

// File: rtl/count_uart_tx.sv
// count_uart_tx: captures a count on the gate edge and sends it as "DDD\r\n" over 8N1 UART
// clk_in, rst_n_in: clock, async active-low reset; bus: count/gate in, tx/busy/overrun out
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input logic clk_in,
    input logic rst_n_in,
    count_uart_tx_if.slave bus
);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
    state_t     state, next;
    logic       load_q, load_rise, overrun, start, ser_busy, done;
    logic [7:0] value_q, tx_byte;
    logic [1:0] hund;
    logic [3:0] tens;
    logic [2:0] idx;
    assign load_rise = bus.load_in && !load_q;
    assign bus.busy_out = state != IDLE;
    assign bus.overrun_out = overrun;
    // after conversion value_q holds only the ones remainder
    assign tx_byte = idx == 3'd0 ? ASCII_ZERO + {6'd0, hund} :
                     idx == 3'd1 ? ASCII_ZERO + {4'd0, tens} :
                     idx == 3'd2 ? ASCII_ZERO + {4'd0, value_q[3:0]} :
                     idx == 3'd3 ? ASCII_CR : ASCII_LF;
    always_comb begin
        next = state;
        start = 1'b0;
        case (state)
            IDLE: next = load_rise ? CONV : IDLE;
            CONV: next = value_q < 8'd10 ? SEND : CONV;
            SEND: begin
                start = !ser_busy;
                next = ser_busy ? SEND : WAIT;
            end
            WAIT: next = !done ? WAIT : idx == LAST_IDX ? IDLE : SEND;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else state <= next;
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            load_q <= 1'b0;
            overrun <= 1'b0;
            value_q <= '0;
            hund <= '0;
            tens <= '0;
            idx <= '0;
        end else begin
            load_q <= bus.load_in;
            if (load_rise && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (load_rise) begin
                    // the counter holds the count only during the gate cycle
                    value_q <= bus.data_in;
                    hund <= '0;
                    tens <= '0;
                    idx <= '0;
                end
                CONV: if (value_q >= 8'd100) begin
                    value_q <= value_q - 8'd100;
                    hund <= hund + 2'd1;
                end else if (value_q >= 8'd10) begin
                    value_q <= value_q - 8'd10;
                    tens <= tens + 4'd1;
                end
                WAIT: if (done) idx <= idx + 3'd1;
                default: ;
            endcase
        end
    end
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .start(start),
        .data(tx_byte),
        .tx(bus.tx_out),
        .busy(ser_busy),
        .done(done)
    );
endmodule

// File: tb/tb_count_uart_tx.sv
// tb_count_uart_tx: directed self-checking bench decoding the UART line of count_uart_tx
module tb_count_uart_tx;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic rst_n_in = 1'b0;
    int checks = 0;
    int errors = 0;
    count_uart_tx_if bus();
    count_uart_tx #(.CLK_FREQ(40), .BAUD(10), .CLKS_PER_BIT(CPB)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n_in),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic pulse(input logic [7:0] d);
        @(negedge clk);
        bus.data_in = d;
        bus.load_in = 1'b1;
        @(negedge clk);
        bus.load_in = 1'b0;
    endtask
    task automatic wait_start(output bit ok);
        int n = 0;
        while (bus.tx_out !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = n < 200;
        if (!ok) chk("start_timeout", 32'd0, 32'd1);
    endtask
    task automatic recv_byte(output logic [7:0] b, input bit do_pulse);
        bit ok;
        b = 8'h00;
        wait_start(ok);
        if (!ok) return;
        if (do_pulse) begin
            bus.load_in = 1'b1;
            @(negedge clk);
            bus.load_in = 1'b0;
            @(negedge clk);
        end else repeat (2) @(negedge clk);
        chk("start_bit", 32'(bus.tx_out), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = bus.tx_out;
        end
        repeat (CPB) @(negedge clk);
        chk("stop_bit", 32'(bus.tx_out), 32'd1);
    endtask
    task automatic recv_frame(input string tag, input logic [39:0] exp, input int pulse_byte);
        logic [7:0] b;
        for (int i = 0; i < 5; i++) begin
            recv_byte(b, i == pulse_byte);
            chk($sformatf("%s_b%0d", tag, i), 32'(b), 32'(exp[39-8*i -: 8]));
        end
        @(negedge clk);
        chk({tag, "_busy_last"}, 32'(bus.busy_out), 32'd1);
        @(negedge clk);
        chk({tag, "_busy_end"}, 32'(bus.busy_out), 32'd0);
    endtask
    task automatic watch_idle(input int n, output int bad);
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.tx_out !== 1'b1 || bus.busy_out !== 1'b0) bad++;
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "timeout");
    end
    initial begin
        int bad;
        logic [7:0] b;
        bit ok;
        bus.data_in = 8'd0;
        bus.load_in = 1'b0;
        #12;
        chk("rst_tx", 32'(bus.tx_out), 32'd1);
        chk("rst_busy", 32'(bus.busy_out), 32'd0);
        chk("rst_ovr", 32'(bus.overrun_out), 32'd0);
        @(negedge clk);
        rst_n_in = 1'b1;
        watch_idle(100, bad);
        chk("idle_100", 32'(bad), 32'd0);
        chk("idle_ovr", 32'(bus.overrun_out), 32'd0);
        pulse(8'd123);
        recv_frame("f123", 40'h31_32_33_0D_0A, -1);
        pulse(8'd0);
        recv_frame("f000", 40'h30_30_30_0D_0A, -1);
        pulse(8'd255);
        recv_frame("f255", 40'h32_35_35_0D_0A, -1);
        pulse(8'd250);
        bus.data_in = 8'd9;
        recv_frame("f250", 40'h32_35_30_0D_0A, -1);
        chk("ovr_still_clear", 32'(bus.overrun_out), 32'd0);
        pulse(8'd123);
        recv_frame("fovr", 40'h31_32_33_0D_0A, 2);
        chk("ovr_set", 32'(bus.overrun_out), 32'd1);
        watch_idle(100, bad);
        chk("no_extra_frame", 32'(bad), 32'd0);
        chk("ovr_sticky", 32'(bus.overrun_out), 32'd1);
        @(negedge clk);
        bus.data_in = 8'd42;
        bus.load_in = 1'b1;
        recv_frame("fhold", 40'h30_34_32_0D_0A, -1);
        watch_idle(100, bad);
        chk("hold_one_frame", 32'(bad), 32'd0);
        bus.load_in = 1'b0;
        watch_idle(50, bad);
        chk("hold_release_idle", 32'(bad), 32'd0);
        pulse(8'd200);
        recv_byte(b, 1'b0);
        chk("rst_mid_b0", 32'(b), 32'h32);
        recv_byte(b, 1'b0);
        chk("rst_mid_b1", 32'(b), 32'h30);
        wait_start(ok);
        repeat (5) @(negedge clk);
        rst_n_in = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(bus.tx_out), 32'd1);
        chk("rst_mid_busy", 32'(bus.busy_out), 32'd0);
        chk("rst_mid_ovr", 32'(bus.overrun_out), 32'd0);
        @(negedge clk);
        rst_n_in = 1'b1;
        watch_idle(20, bad);
        chk("post_rst_idle", 32'(bad), 32'd0);
        pulse(8'd7);
        recv_frame("f007", 40'h30_30_37_0D_0A, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
